reg_file_mp: RTL and testbench

Parametrised multi-port register file for the FEC processor datapath, next generation of the single-write/dual-read register file. It provides NR combinational read ports, two prioritised write ports and a hardwired zero register. Two snoop outputs at parameter-selected indices replace the fixed register-13/14 taps. A sequenced clear engine zeroes the array one entry per cycle without stalling writes.

---
 rtl/reg_file_mp.sv | 112 +++++++++++
 tb/tb_reg_file_mp.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: NR combinational read ports, two prioritised write ports,
// hardwired zero register, two snoop taps and a clear sweep. Option macro: REG_FILE_BYPASS_EN.
module reg_file_mp #(
  parameter int W        = 8,
  parameter int D        = 4,
  parameter int NR       = 2,
  parameter int ZERO_REG = 15,
  parameter int SNOOP0   = 13,
  parameter int SNOOP1   = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we0,
  input  logic [D-1:0]    waddr0,
  input  logic [W-1:0]    wdata0,
  input  logic            we1,
  input  logic [D-1:0]    waddr1,
  input  logic [W-1:0]    wdata1,
  input  logic [NR*D-1:0] raddr,
  output logic [NR*W-1:0] rdata,
  input  logic            clear_req,
  output logic            clear_busy,
  output logic            clear_done,
  output logic [W-1:0]    data_snoop0,
  output logic [W-1:0]    data_snoop1
);
  localparam int           N    = 2**D;
  localparam logic [D-1:0] ZR   = D'(ZERO_REG);
  localparam logic [D-1:0] LAST = D'(N - 1);

  // IDLE: waiting for clear_req | SWEEP: zeroing entry idx_q this cycle
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [D-1:0] idx_q, idx_d;
  logic         done_q, done_d;
  logic         sweep_we;
  logic [W-1:0] mem_q [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    sweep_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        sweep_we = 1'b1;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clear_busy = (state_q == SWEEP);
  assign clear_done = done_q;

  // The zero register is never written, so it holds its reset value forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i != ZERO_REG) begin
          if (we1 && waddr1 == D'(i))               mem_q[i] <= wdata1;
          else if (we0 && waddr0 == D'(i))          mem_q[i] <= wdata0;
          else if (sweep_we && idx_q == D'(i))      mem_q[i] <= '0;
        end
      end
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [D-1:0] ra;
    logic [W-1:0] rd;
    assign ra = raddr[k*D +: D];
    always_comb begin
      rd = mem_q[ra];
      if (ra == ZR) rd = '0;
`ifdef REG_FILE_BYPASS_EN
      else if (we1 && ra == waddr1) rd = wdata1;
      else if (we0 && ra == waddr0) rd = wdata0;
`endif
    end
    assign rdata[k*W +: W] = rd;
  end

  assign data_snoop0 = mem_q[SNOOP0];
  assign data_snoop1 = mem_q[SNOOP1];

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus pushes expected outputs, a negedge monitor compares.
module tb_reg_file_mp;
  localparam int W = 8, D = 4, NR = 2, N = 16;
  localparam int ZERO = 15, SN0 = 13, SN1 = 14;

  logic            clk = 1'b1;
  logic            reset;
  logic            we0, we1;
  logic [D-1:0]    waddr0, waddr1;
  logic [W-1:0]    wdata0, wdata1;
  logic [NR*D-1:0] raddr;
  logic [NR*W-1:0] rdata;
  logic            clear_req, clear_busy, clear_done;
  logic [W-1:0]    data_snoop0, data_snoop1;
  bit              test_finished = 1'b0;

  always #5 clk = ~clk;

  reg_file_mp #(.W(W), .D(D), .NR(NR), .ZERO_REG(ZERO), .SNOOP0(SN0), .SNOOP1(SN1)) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .data_snoop0(data_snoop0), .data_snoop1(data_snoop1)
  );

  typedef struct {
    string        name;
    int           kind;
    int           port;
    logic [W-1:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: array contents plus the cycle a sweep was accepted.
  logic [W-1:0] m [N];
  int           sw_start = -1;
  int           done_at  = -1;

  function automatic void push(string n, int kind, int port, logic [W-1:0] e);
    chk_t c;
    c.name = n; c.kind = kind; c.port = port; c.exp = e;
    sb.push_back(c);
  endfunction

  always @(negedge clk) begin
    chk_t         c;
    logic [W-1:0] act;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      case (c.kind)
        0:       act = rdata[c.port*W +: W];
        1:       act = data_snoop0;
        2:       act = data_snoop1;
        3:       act = {{(W-1){1'b0}}, clear_busy};
        default: act = {{(W-1){1'b0}}, clear_done};
      endcase
      n_checks++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", c.name, cyc, act, c.exp);
      end
    end
  end

  initial begin
    #100000;
    n_checks++;
    if (!test_finished) begin
      n_fail++;
      $display("FAIL watchdog: wait expired at cycle %0d before end of test", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic step();
    bit           busy_e;
    int           a, j;
    logic [W-1:0] e;
    busy_e = !reset && sw_start >= 0 && cyc > sw_start && cyc <= sw_start + N;
    for (int k = 0; k < NR; k++) begin
      a = int'(raddr[k*D +: D]);
      e = (a == ZERO) ? '0 : m[a];
`ifdef REG_FILE_BYPASS_EN
      if (!reset && a != ZERO) begin
        if (we1 && int'(waddr1) == a)      e = wdata1;
        else if (we0 && int'(waddr0) == a) e = wdata0;
      end
`endif
      push($sformatf("rdata%0d", k), 0, k, e);
    end
    push("snoop0", 1, 0, m[SN0]);
    push("snoop1", 2, 0, m[SN1]);
    push("clear_busy", 3, 0, W'(busy_e));
    push("clear_done", 4, 0, W'(!reset && done_at == cyc));
    @(posedge clk);
    if (!reset) begin
      if (busy_e) begin
        j = cyc - sw_start - 1;
        m[j] = '0;
        if (j == N - 1) begin
          done_at  = cyc + 1;
          sw_start = -1;
        end
      end
      if (we0 && int'(waddr0) != ZERO) m[waddr0] = wdata0;
      if (we1 && int'(waddr1) != ZERO) m[waddr1] = wdata1;
      if (!busy_e && clear_req) sw_start = cyc;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_in();
    we0 = 1'b0; we1 = 1'b0; clear_req = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic read_all();
    for (int i = 0; i < N / 2; i++) begin
      idle_in();
      raddr = {D'(2*i + 1), D'(2*i)};
      step();
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = '0;
    sw_start = -1;
    done_at  = -1;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    raddr = '0;
    model_reset();
    #1;
    n_checks++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b0 || data_snoop0 !== '0 ||
        data_snoop1 !== '0 || rdata !== '0) begin
      n_fail++;
      $display("FAIL reset state: busy %b done %b snoop0 %h snoop1 %h rdata %h",
               clear_busy, clear_done, data_snoop0, data_snoop1, rdata);
    end
    read_all();
    reset = 1'b0;
    read_all();

    // Dual write to the same address, then a write to the zero register.
    idle_in(); raddr = {D'(15), D'(5)};
    we0 = 1'b1; waddr0 = 5; wdata0 = 8'h11;
    we1 = 1'b1; waddr1 = 5; wdata1 = 8'h22;
    step();
    idle_in(); raddr = {D'(15), D'(5)};
    we1 = 1'b1; waddr1 = 15; wdata1 = 8'hFF;
    step();
    idle_in(); raddr = {D'(15), D'(5)};
    step();

    // Same-cycle read of a written address; snoop tap written in the same cycle.
    idle_in(); raddr = {D'(13), D'(3)};
    we0 = 1'b1; waddr0 = 3;  wdata0 = 8'hA5;
    we1 = 1'b1; waddr1 = 13; wdata1 = 8'h3C;
    step();
    idle_in(); raddr = {D'(13), D'(3)};
    step();

    // Fill, sweep with mid-sweep writes and an ignored re-request.
    for (int i = 0; i < N / 2; i++) begin
      idle_in(); raddr = (NR*D)'($urandom);
      we0 = 1'b1; waddr0 = D'(2*i);     wdata0 = 8'h5A;
      we1 = 1'b1; waddr1 = D'(2*i + 1); wdata1 = 8'h5A;
      step();
    end
    idle_in(); clear_req = 1'b1; step();
    for (int b = 1; b <= 18; b++) begin
      idle_in(); raddr = (NR*D)'($urandom);
      if (b == 2) begin we1 = 1'b1; waddr1 = 12; wdata1 = 8'h99; end
      if (b == 5) begin we0 = 1'b1; waddr0 = 2;  wdata0 = 8'h77; end
      if (b == 8) clear_req = 1'b1;
      step();
    end
    read_all();

    // Reset in the middle of a sweep, then a fresh full sweep.
    for (int i = 0; i < N / 2; i++) begin
      idle_in(); raddr = (NR*D)'($urandom);
      we0 = 1'b1; waddr0 = D'(2*i);     wdata0 = D'(i) + 8'h40;
      we1 = 1'b1; waddr1 = D'(2*i + 1); wdata1 = D'(i) + 8'h80;
      step();
    end
    idle_in(); clear_req = 1'b1; step();
    for (int b = 1; b <= 6; b++) begin idle_in(); step(); end
    reset = 1'b1;
    model_reset();
    read_all();
    reset = 1'b0;
    idle_in(); clear_req = 1'b1; step();
    for (int b = 1; b <= 18; b++) begin idle_in(); raddr = (NR*D)'($urandom); step(); end
    read_all();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      we0       = 1'($urandom_range(0, 1));
      we1       = 1'($urandom_range(0, 2) == 0);
      waddr0    = D'($urandom);
      waddr1    = ($urandom_range(0, 3) == 0) ? waddr0 : D'($urandom);
      wdata0    = W'($urandom);
      wdata1    = W'($urandom);
      clear_req = ($urandom_range(0, 24) == 0);
      raddr     = ($urandom_range(0, 3) == 0) ? {waddr1, waddr0} : (NR*D)'($urandom);
      step();
    end
    idle_in();
    read_all();

    #10;
    test_finished = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
